tracer_retire_buffer: RTL

//  Capture stage directly upstream of the instruction tracer. Samples the core's
//  per-cycle retirement record, time-stamps it, sequence-numbers it and normalises

---
 rtl/tracer_retire_buffer_if.sv | 41 ++++
 rtl/tracer_retire_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tracer_retire_buffer_if.sv
// Record handshake between the retire buffer and the instruction tracer.
//   master : retire buffer side; drives the head record and rec_valid_o,
//            samples rec_ready_i.
//   slave  : tracer side; samples the record, drives rec_ready_i.
// Signals:
//   rec_valid_o      record available at FIFO head
//   rec_ready_i      tracer accepts the head record
//   rec_pc_o         PC of the retired instruction
//   rec_insn_o       instruction bits, upper half zero when compressed
//   rec_rd_addr_o    destination register (0 = none)
//   rec_rd_wdata_o   value written to rd, zero when rd is x0
//   rec_mem_addr_o   load/store/AMO effective address
//   rec_trap_o       instruction trapped instead of retiring
//   rec_compressed_o original encoding was 16-bit
//   rec_cycle_o      cycle counter at capture
//   rec_seq_o        retirement sequence number at capture
interface tracer_retire_buffer_if;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [31:0] rec_pc_o;
  logic [31:0] rec_insn_o;
  logic [4:0]  rec_rd_addr_o;
  logic [31:0] rec_rd_wdata_o;
  logic [31:0] rec_mem_addr_o;
  logic        rec_trap_o;
  logic        rec_compressed_o;
  logic [63:0] rec_cycle_o;
  logic [31:0] rec_seq_o;

  modport master (
    output rec_valid_o, rec_pc_o, rec_insn_o, rec_rd_addr_o, rec_rd_wdata_o,
           rec_mem_addr_o, rec_trap_o, rec_compressed_o, rec_cycle_o, rec_seq_o,
    input  rec_ready_i
  );

  modport slave (
    input  rec_valid_o, rec_pc_o, rec_insn_o, rec_rd_addr_o, rec_rd_wdata_o,
           rec_mem_addr_o, rec_trap_o, rec_compressed_o, rec_cycle_o, rec_seq_o,
    output rec_ready_i
  );
endinterface

// File: rtl/tracer_retire_buffer.sv
// Capture stage in front of the instruction tracer. Each retirement record is
// time-stamped with a free-running 64-bit cycle counter, tagged with a 32-bit
// sequence number, normalised (compressed insn, rd/wdata cleanup) and queued
// in a DEPTH-entry FIFO so a slow tracer never back-pressures the core.
// Records arriving while the FIFO is full (and nothing is popped) are dropped
// and counted.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          synchronous FIFO clear; counters are kept
//   ret_*_i          per-cycle retirement record from the core
//   rec              record handshake towards the tracer (master side)
//   level_o          number of stored records
//   drop_cnt_o       saturating count of records lost to overflow
//   overflow_o       sticky flag, set on the first drop
module tracer_retire_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     ret_valid_i,
  input  logic [31:0]              ret_pc_i,
  input  logic [31:0]              ret_insn_i,
  input  logic [4:0]               ret_rd_addr_i,
  input  logic [31:0]              ret_rd_wdata_i,
  input  logic [31:0]              ret_mem_addr_i,
  input  logic                     ret_trap_i,
  tracer_retire_buffer_if.master   rec,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic        trap;
    logic        compressed;
    logic [63:0] cycle;
    logic [31:0] seq;
  } rec_t;

  // Build the stored record from the raw retirement port. A compressed
  // encoding keeps only its low half; a trapped instruction or a write to x0
  // carries no register result.
  function automatic rec_t normalise(
    input logic [31:0] pc,
    input logic [31:0] insn,
    input logic [4:0]  rd_addr,
    input logic [31:0] rd_wdata,
    input logic [31:0] mem_addr,
    input logic        trap,
    input logic [63:0] cycle,
    input logic [31:0] seq
  );
    rec_t r;
    r.pc         = pc;
    r.compressed = (insn[1:0] != 2'b11);
    r.insn       = r.compressed ? {16'h0000, insn[15:0]} : insn;
    r.rd_addr    = trap ? 5'd0 : rd_addr;
    r.rd_wdata   = (r.rd_addr == 5'd0) ? 32'd0 : rd_wdata;
    r.mem_addr   = mem_addr;
    r.trap       = trap;
    r.cycle      = cycle;
    r.seq        = seq;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [63:0]      cycle_q;
  logic [31:0]      seq_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             overflow_q;
  rec_t             mem_q [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  rec_t rec_p0;
  rec_t head;
  rec_t head_vis;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index but opposite wrap bit: writer is one lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && rec.rec_ready_i;
  // A flush discards the same-cycle retirement without counting it as a drop.
  assign push  = ret_valid_i && !flush_i && (!full || pop);
  assign drop  = ret_valid_i && !flush_i && full && !pop;

  // ---- p0: capture and normalise the incoming retirement ----
  assign rec_p0 = normalise(ret_pc_i, ret_insn_i, ret_rd_addr_i, ret_rd_wdata_i,
                            ret_mem_addr_i, ret_trap_i, cycle_q, seq_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q    <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      // Sequence advances for every retirement, stored or not, so the tracer
      // can see gaps.
      if (ret_valid_i) begin
        seq_q <= seq_q + 32'd1;
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
      if (drop) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
        overflow_q <= 1'b1;
      end
    end
  end

  // ---- p1: FIFO storage (data only, no reset) ----
  // On a full push+pop the write lands in the slot being read; the read sees
  // the old head because the array updates at the edge.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec_p0;
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Head fields read as zero when nothing is queued, so the outputs are clean
  // after reset or flush even though the storage itself is not cleared.
  always_comb begin
    head_vis = '0;
    if (!empty) begin
      head_vis = head;
    end
  end

  assign rec.rec_valid_o      = !empty;
  assign rec.rec_pc_o         = head_vis.pc;
  assign rec.rec_insn_o       = head_vis.insn;
  assign rec.rec_rd_addr_o    = head_vis.rd_addr;
  assign rec.rec_rd_wdata_o   = head_vis.rd_wdata;
  assign rec.rec_mem_addr_o   = head_vis.mem_addr;
  assign rec.rec_trap_o       = head_vis.trap;
  assign rec.rec_compressed_o = head_vis.compressed;
  assign rec.rec_cycle_o      = head_vis.cycle;
  assign rec.rec_seq_o        = head_vis.seq;

  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule
